// File: rtl/barrel_pkg.sv
// barrel_pkg: shared width, amount and rotate types for the pipelined left rotator.
`ifndef WIDTH
`define WIDTH 8
`endif
package barrel_pkg;
    localparam int WIDTH  = `WIDTH;
    localparam int STAGES = $clog2(WIDTH);
    typedef logic [WIDTH-1:0]  word_t;
    typedef logic [STAGES-1:0] amt_t;
    function automatic word_t rotl(word_t x, int k);
        int m;
        m = k % WIDTH;
        return (m == 0) ? x : word_t'((x << m) | (x >> (WIDTH - m)));
    endfunction
endpackage

// File: rtl/barrel_rotl_stage.sv
// barrel_rotl_stage: one registered rotate stage, rotating left by SHIFT when its amount bit is set.
module barrel_rotl_stage
    import barrel_pkg::*;
#(
    parameter int  WIDTH  = barrel_pkg::WIDTH,
    parameter int  SHIFT  = 1,
    localparam int STAGES = $clog2(WIDTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_vld,
    input  logic [WIDTH-1:0]  i_data,
    input  logic [STAGES-1:0] i_amt,
    input  logic              i_rdy,
    output logic              o_rdy,
    output logic              o_vld,
    output logic [WIDTH-1:0]  o_data,
    output logic [STAGES-1:0] o_amt
);
    localparam int B = $clog2(SHIFT);
    logic              r_vld;
    logic [WIDTH-1:0]  r_data;
    logic [STAGES-1:0] r_amt;
    logic [WIDTH-1:0]  w_rot;
    assign w_rot  = {i_data[WIDTH-1-SHIFT:0], i_data[WIDTH-1:WIDTH-SHIFT]};
    // a stage may load when empty or when its contents leave this cycle
    assign o_rdy  = ~r_vld | i_rdy;
    assign o_vld  = r_vld;
    assign o_data = r_data;
    assign o_amt  = r_amt;
    always_ff @(posedge clk) begin
        if (rst) begin
            r_vld  <= 1'b0;
            r_data <= '0;
            r_amt  <= '0;
        end else if (o_rdy) begin
            r_vld  <= i_vld;
            r_data <= i_amt[B] ? w_rot : i_data;
            r_amt  <= i_amt;
        end
    end
endmodule

// File: rtl/barrel_shift_left_pipe.sv
// barrel_shift_left_pipe: log2(WIDTH)-stage pipelined rotate-left with valid/ready on both sides.
module barrel_shift_left_pipe
    import barrel_pkg::*;
#(
    parameter int  WIDTH  = barrel_pkg::WIDTH,
    localparam int STAGES = $clog2(WIDTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_vld,
    output logic              in_rdy,
    input  logic [WIDTH-1:0]  in,
    input  logic [STAGES-1:0] rl,
    output logic              out_vld,
    input  logic              out_rdy,
    output logic [WIDTH-1:0]  out_lh
);
    // index 0 is the input port, index s+1 is the output of stage s
    logic              w_vld  [STAGES+1];
    logic              w_rdy  [STAGES+1];
    logic [WIDTH-1:0]  w_data [STAGES+1];
    logic [STAGES-1:0] w_amt  [STAGES+1];
    assign w_vld[0]      = in_vld;
    assign w_data[0]     = in;
    assign w_amt[0]      = rl;
    assign w_rdy[STAGES] = out_rdy;
    assign in_rdy        = w_rdy[0];
    assign out_vld       = w_vld[STAGES];
    assign out_lh        = w_data[STAGES];
    for (genvar s = 0; s < STAGES; s++) begin : g_stage
        barrel_rotl_stage #(.WIDTH(WIDTH), .SHIFT(2 ** s)) u_stage (
            .clk    (clk),
            .rst    (rst),
            .i_vld  (w_vld[s]),
            .i_data (w_data[s]),
            .i_amt  (w_amt[s]),
            .i_rdy  (w_rdy[s+1]),
            .o_rdy  (w_rdy[s]),
            .o_vld  (w_vld[s+1]),
            .o_data (w_data[s+1]),
            .o_amt  (w_amt[s+1])
        );
    end
endmodule

// File: tb/tb_barrel_shift_left_pipe.sv
// tb_barrel_shift_left_pipe: randomized and directed checks of the rotate pipe against a bit-mapping model.
module tb_barrel_shift_left_pipe;
    localparam int W = 8;
    logic         clk = 1'b0;
    logic         rst, in_vld, in_rdy, out_vld, out_rdy;
    logic [W-1:0] din, out_lh;
    logic [2:0]   rl;
    int           checks = 0;
    int           failures = 0;

    always #5 clk = ~clk;

    barrel_shift_left_pipe dut (
        .clk     (clk),
        .rst     (rst),
        .in_vld  (in_vld),
        .in_rdy  (in_rdy),
        .in      (din),
        .rl      (rl),
        .out_vld (out_vld),
        .out_rdy (out_rdy),
        .out_lh  (out_lh)
    );

    // input bit i lands at position (i+k) mod W
    function automatic logic [W-1:0] model(logic [W-1:0] x, int k);
        logic [W-1:0] r;
        for (int i = 0; i < W; i++) r[(i + k) % W] = x[i];
        return r;
    endfunction

    task automatic test_reset();
        rst = 1'b1; in_vld = 1'b0; out_rdy = 1'b1; din = '0; rl = '0;
        repeat (2) @(negedge clk);
        #1;
        checks++; if (out_vld !== 1'b0) begin failures++; $display("FAIL reset_out_vld got=%b exp=0", out_vld); end
        checks++; if (out_lh !== 8'h00) begin failures++; $display("FAIL reset_out_lh got=%h exp=00", out_lh); end
        checks++; if (in_rdy !== 1'b1) begin failures++; $display("FAIL reset_in_rdy got=%b exp=1", in_rdy); end
        rst = 1'b0;
    endtask

    task automatic test_directed();
        logic [W-1:0] vi [4] = '{8'h81, 8'hA5, 8'h01, 8'h3C};
        logic [2:0]   ra [4] = '{3'd1, 3'd4, 3'd7, 3'd0};
        logic [W-1:0] ve [4] = '{8'h03, 8'h5A, 8'h80, 8'h3C};
        int n;
        for (int t = 0; t < 4; t++) begin
            @(negedge clk);
            in_vld = 1'b1; din = vi[t]; rl = ra[t]; out_rdy = 1'b1;
            #1;
            checks++; if (in_rdy !== 1'b1) begin failures++; $display("FAIL directed_accept[%0d] in_rdy=%b exp=1", t, in_rdy); end
            @(negedge clk);
            in_vld = 1'b0;
            n = 1;
            while (out_vld !== 1'b1 && n < 10) begin
                @(negedge clk);
                n++;
            end
            checks++; if (n != 3) begin failures++; $display("FAIL directed_latency[%0d] got=%0d exp=3", t, n); end
            checks++; if (out_lh !== ve[t]) begin failures++; $display("FAIL directed_data[%0d] got=%h exp=%h", t, out_lh, ve[t]); end
        end
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] ex [16];
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            out_rdy = 1'b1;
            if (c < 16) begin
                in_vld = 1'b1; din = W'($urandom); rl = 3'($urandom);
                ex[c] = model(din, int'(rl));
            end else in_vld = 1'b0;
            #1;
            if (c < 16) begin
                checks++; if (in_rdy !== 1'b1) begin failures++; $display("FAIL b2b_in_rdy c=%0d got=%b exp=1", c, in_rdy); end
            end
            if (c >= 3 && c < 19) begin
                checks++;
                if (out_vld !== 1'b1 || out_lh !== ex[c-3]) begin
                    failures++; $display("FAIL b2b_out c=%0d vld=%b data=%h exp vld=1 data=%h", c, out_vld, out_lh, ex[c-3]);
                end
            end else begin
                checks++; if (out_vld !== 1'b0) begin failures++; $display("FAIL b2b_idle c=%0d vld=%b exp=0", c, out_vld); end
            end
        end
    endtask

    task automatic test_stall();
        logic [W-1:0] ws [6];
        logic [2:0]   ra [6];
        logic [W-1:0] ex [6];
        int k = 0;
        int r = 0;
        for (int i = 0; i < 6; i++) begin
            ws[i] = W'($urandom); ra[i] = 3'($urandom); ex[i] = model(ws[i], int'(ra[i]));
        end
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            out_rdy = 1'b0; in_vld = 1'b1; din = ws[k]; rl = ra[k];
            #1;
            checks++; if (in_rdy !== (c < 3)) begin failures++; $display("FAIL stall_in_rdy c=%0d got=%b exp=%b", c, in_rdy, c < 3); end
            if (in_rdy === 1'b1) k++;
            if (c >= 3) begin
                checks++;
                if (out_vld !== 1'b1 || out_lh !== ex[0]) begin
                    failures++; $display("FAIL stall_hold c=%0d vld=%b data=%h exp vld=1 data=%h", c, out_vld, out_lh, ex[0]);
                end
            end
        end
        for (int c = 0; c < 30 && r < 6; c++) begin
            @(negedge clk);
            out_rdy = 1'b1;
            in_vld = (k < 6);
            if (k < 6) begin din = ws[k]; rl = ra[k]; end
            #1;
            if (in_vld && in_rdy) k++;
            if (out_vld) begin
                checks++;
                if (out_lh !== ex[r]) begin failures++; $display("FAIL stall_drain[%0d] got=%h exp=%h", r, out_lh, ex[r]); end
                r++;
            end
        end
        in_vld = 1'b0;
        checks++; if (r != 6 || k != 6) begin failures++; $display("FAIL stall_count got out=%0d in=%0d exp=6/6", r, k); end
    endtask

    task automatic test_random();
        logic [W-1:0] q [$];
        logic [W-1:0] held = '0;
        logic         stalled = 1'b0;
        logic [W-1:0] e;
        int sent = 0;
        int rcvd = 0;
        for (int cyc = 0; cyc < 20000 && rcvd < 1000; cyc++) begin
            @(negedge clk);
            in_vld = (sent < 1000) && ($urandom_range(0, 3) != 0);
            din = W'($urandom); rl = 3'($urandom);
            out_rdy = ($urandom_range(0, 2) != 0);
            #1;
            if (stalled) begin
                checks++;
                if (out_vld !== 1'b1 || out_lh !== held) begin
                    failures++; $display("FAIL rand_stable cyc=%0d vld=%b data=%h exp vld=1 data=%h", cyc, out_vld, out_lh, held);
                end
            end
            stalled = out_vld && !out_rdy;
            held = out_lh;
            if (in_vld && in_rdy) begin q.push_back(model(din, int'(rl))); sent++; end
            if (out_vld && out_rdy) begin
                checks++;
                if (q.size() == 0) begin
                    failures++; $display("FAIL rand_spurious cyc=%0d got=%h exp=none", cyc, out_lh);
                end else begin
                    e = q.pop_front();
                    if (out_lh !== e) begin failures++; $display("FAIL rand_data[%0d] got=%h exp=%h", rcvd, out_lh, e); end
                end
                rcvd++;
            end
        end
        in_vld = 1'b0;
        checks++; if (rcvd != 1000 || q.size() != 0) begin failures++; $display("FAIL rand_count got=%0d left=%0d exp=1000/0", rcvd, q.size()); end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            out_rdy = 1'b0; in_vld = 1'b1; din = W'($urandom); rl = 3'($urandom);
        end
        @(negedge clk);
        checks++; if (out_vld !== 1'b1) begin failures++; $display("FAIL mid_full out_vld=%b exp=1", out_vld); end
        in_vld = 1'b0; rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++; if (out_vld !== 1'b0) begin failures++; $display("FAIL mid_out_vld got=%b exp=0", out_vld); end
        checks++; if (in_rdy !== 1'b1) begin failures++; $display("FAIL mid_in_rdy got=%b exp=1", in_rdy); end
        out_rdy = 1'b1;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            checks++; if (out_vld !== 1'b0) begin failures++; $display("FAIL mid_stale c=%0d vld=%b exp=0", c, out_vld); end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_directed();
        test_back_to_back();
        test_stall();
        test_random();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
